// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - raster 3x3 window scan controller: window read, filter handshake, centre write
module window_scan_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd,
    output logic [7:0]  addr_row_r,
    output logic [7:0]  addr_col_r,
    input  logic [7:0]  sw_pixel_1,
    input  logic [7:0]  sw_pixel_2,
    input  logic [7:0]  sw_pixel_3,
    input  logic [7:0]  sw_pixel_4,
    input  logic [7:0]  sw_pixel_5,
    input  logic [7:0]  sw_pixel_6,
    input  logic [7:0]  sw_pixel_7,
    input  logic [7:0]  sw_pixel_8,
    input  logic [7:0]  sw_pixel_9,
    output logic        wr,
    output logic [7:0]  addr_row_w,
    output logic [7:0]  addr_col_w,
    output logic [7:0]  cl_pixel,
    output logic [71:0] win_data,
    output logic        win_valid,
    input  logic        win_ready,
    input  logic [7:0]  res_pixel,
    input  logic        res_valid,
    output logic        res_ready
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RD_A = 4'd1;
    localparam logic [3:0] S_RD_D = 4'd2;
    localparam logic [3:0] S_CAP  = 4'd3;
    localparam logic [3:0] S_WIN  = 4'd4;
    localparam logic [3:0] S_RES  = 4'd5;
    localparam logic [3:0] S_WR_A = 4'd6;
    localparam logic [3:0] S_WR_C = 4'd7;
    localparam logic [3:0] S_ADV  = 4'd8;
    localparam logic [3:0] S_DONE = 4'd9;

    localparam logic [7:0] COL_LAST = 8'(IMG_W - 3);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - 3);

    logic [3:0]  state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [71:0] win_q, win_d;
    logic [7:0]  cl_q, cl_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        win_d   = win_q;
        cl_d    = cl_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: state_d = S_RD_D;
            S_RD_D: state_d = S_CAP;
            S_CAP: begin
                win_d   = {sw_pixel_9, sw_pixel_8, sw_pixel_7, sw_pixel_6, sw_pixel_5,
                           sw_pixel_4, sw_pixel_3, sw_pixel_2, sw_pixel_1};
                state_d = S_WIN;
            end
            S_WIN: begin
                if (win_ready) state_d = S_RES;
            end
            S_RES: begin
                if (res_valid) begin
                    cl_d    = res_pixel;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: state_d = S_WR_C;
            S_WR_C: state_d = S_ADV;
            S_ADV: begin
                // Last-window test uses the coordinates of the window just written
                if (col_q == COL_LAST) begin
                    col_d = 8'd0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
                if (row_q == ROW_LAST && col_q == COL_LAST) state_d = S_DONE;
                else                                        state_d = S_RD_A;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= 8'd0;
            col_q   <= 8'd0;
            win_q   <= 72'd0;
            cl_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
            cl_q    <= cl_d;
        end
    end

    always_comb begin
        rd         = (state_q == S_RD_A) || (state_q == S_RD_D);
        wr         = (state_q == S_WR_A) || (state_q == S_WR_C);
        addr_row_r = rd ? row_q : 8'd0;
        addr_col_r = rd ? col_q : 8'd0;
        addr_row_w = wr ? row_q + 8'd1 : 8'd0;
        addr_col_w = wr ? col_q + 8'd1 : 8'd0;
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        win_valid  = (state_q == S_WIN);
        res_ready  = (state_q == S_RES);
        win_data   = win_q;
        cl_pixel   = cl_q;
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - bench for window_scan_ctrl: 4x4 directed scans and 7x5 randomized scan
module tb_window_scan_ctrl;

    localparam int AW = 4;
    localparam int AH = 4;
    localparam int BW = 7;
    localparam int BH = 5;
    localparam int NWB = (BW - 2) * (BH - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst, start, win_ready, res_valid;
    logic        busy, done, rd, wr, win_valid, res_ready;
    logic [7:0]  addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel, res_pixel;
    logic [71:0] win_data;
    logic [7:0]  sw [1:9];

    logic        start_b, win_ready_b, res_valid_b;
    logic        busy_b, done_b, rd_b, wr_b, win_valid_b, res_ready_b;
    logic [7:0]  addr_row_r_b, addr_col_r_b, addr_row_w_b, addr_col_w_b, cl_pixel_b, res_pixel_b;
    logic [71:0] win_data_b;
    logic [7:0]  sw_b [1:9];

    assign res_pixel   = win_data[39:32];
    assign res_pixel_b = win_data_b[39:32];

    window_scan_ctrl #(.IMG_W(AW), .IMG_H(AH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd(rd), .addr_row_r(addr_row_r), .addr_col_r(addr_col_r),
        .sw_pixel_1(sw[1]), .sw_pixel_2(sw[2]), .sw_pixel_3(sw[3]),
        .sw_pixel_4(sw[4]), .sw_pixel_5(sw[5]), .sw_pixel_6(sw[6]),
        .sw_pixel_7(sw[7]), .sw_pixel_8(sw[8]), .sw_pixel_9(sw[9]),
        .wr(wr), .addr_row_w(addr_row_w), .addr_col_w(addr_col_w), .cl_pixel(cl_pixel),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .res_pixel(res_pixel), .res_valid(res_valid), .res_ready(res_ready)
    );

    window_scan_ctrl #(.IMG_W(BW), .IMG_H(BH)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd(rd_b), .addr_row_r(addr_row_r_b), .addr_col_r(addr_col_r_b),
        .sw_pixel_1(sw_b[1]), .sw_pixel_2(sw_b[2]), .sw_pixel_3(sw_b[3]),
        .sw_pixel_4(sw_b[4]), .sw_pixel_5(sw_b[5]), .sw_pixel_6(sw_b[6]),
        .sw_pixel_7(sw_b[7]), .sw_pixel_8(sw_b[8]), .sw_pixel_9(sw_b[9]),
        .wr(wr_b), .addr_row_w(addr_row_w_b), .addr_col_w(addr_col_w_b), .cl_pixel(cl_pixel_b),
        .win_data(win_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
        .res_pixel(res_pixel_b), .res_valid(res_valid_b), .res_ready(res_ready_b)
    );

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((16 * r + c) % 256);
    endfunction

    // Image memory: a read request presents the 3x3 window at the end of the cycle
    always @(posedge clk) begin
        if (rd)
            for (int k = 0; k < 9; k++) sw[k+1] <= pix(int'(addr_row_r) + k / 3, int'(addr_col_r) + k % 3);
        if (rd_b)
            for (int k = 0; k < 9; k++) sw_b[k+1] <= pix(int'(addr_row_r_b) + k / 3, int'(addr_col_r_b) + k % 3);
    end

    int a_rd_n = 0, a_wr_n = 0, a_done_n = 0, a_conf = 0, a_hold = 0;
    logic [7:0] a_rd_r [64];
    logic [7:0] a_rd_c [64];
    logic [7:0] a_wr_r [64];
    logic [7:0] a_wr_c [64];
    logic [7:0] a_wr_v [64];
    logic       pa_rd = 1'b0, pa_wr = 1'b0;
    logic [7:0] pa_rr, pa_rc, pa_wr_r, pa_wc, pa_wv;

    always @(negedge clk) begin
        if (rst) begin
            pa_rd <= 1'b0;
            pa_wr <= 1'b0;
        end else begin
            if (rd && wr) a_conf <= a_conf + 1;
            if (rd && !pa_rd) begin
                a_rd_r[a_rd_n % 64] <= addr_row_r;
                a_rd_c[a_rd_n % 64] <= addr_col_r;
                a_rd_n <= a_rd_n + 1;
            end
            if (wr && !pa_wr) begin
                a_wr_r[a_wr_n % 64] <= addr_row_w;
                a_wr_c[a_wr_n % 64] <= addr_col_w;
                a_wr_v[a_wr_n % 64] <= cl_pixel;
                a_wr_n <= a_wr_n + 1;
            end
            if ((rd && pa_rd && (addr_row_r !== pa_rr || addr_col_r !== pa_rc)) ||
                (wr && pa_wr && (addr_row_w !== pa_wr_r || addr_col_w !== pa_wc || cl_pixel !== pa_wv)))
                a_hold <= a_hold + 1;
            if (done) a_done_n <= a_done_n + 1;
            pa_rd <= rd; pa_wr <= wr;
            pa_rr <= addr_row_r; pa_rc <= addr_col_r;
            pa_wr_r <= addr_row_w; pa_wc <= addr_col_w; pa_wv <= cl_pixel;
        end
    end

    int b_rd_n = 0, b_wr_n = 0, b_done_n = 0, b_conf = 0, b_err = 0;
    logic       pb_rd = 1'b0, pb_wr = 1'b0;
    logic [7:0] pb_rr, pb_rc, pb_wr_r, pb_wc, pb_wv;

    // Expected window k of a scan is (k / (BW-2), k % (BW-2)) in raster order
    always @(negedge clk) begin
        if (rst) begin
            pb_rd <= 1'b0;
            pb_wr <= 1'b0;
        end else begin
            if (rd_b && wr_b) begin
                b_conf <= b_conf + 1;
                $display("FAIL b_rd_wr_overlap rd=%0b wr=%0b want not both", rd_b, wr_b);
            end
            if (rd_b && !pb_rd) begin
                if (int'(addr_row_r_b) != (b_rd_n % NWB) / (BW - 2) || int'(addr_col_r_b) != (b_rd_n % NWB) % (BW - 2)) begin
                    b_err <= b_err + 1;
                    $display("FAIL b_rd_addr got (%0d,%0d) want (%0d,%0d)", addr_row_r_b, addr_col_r_b,
                             (b_rd_n % NWB) / (BW - 2), (b_rd_n % NWB) % (BW - 2));
                end
                b_rd_n <= b_rd_n + 1;
            end
            if (wr_b && !pb_wr) begin
                if (int'(addr_row_w_b) != (b_wr_n % NWB) / (BW - 2) + 1 || int'(addr_col_w_b) != (b_wr_n % NWB) % (BW - 2) + 1 ||
                    cl_pixel_b !== pix((b_wr_n % NWB) / (BW - 2) + 1, (b_wr_n % NWB) % (BW - 2) + 1)) begin
                    b_err <= b_err + 1;
                    $display("FAIL b_wr got (%0d,%0d)=%h want (%0d,%0d)=%h", addr_row_w_b, addr_col_w_b, cl_pixel_b,
                             (b_wr_n % NWB) / (BW - 2) + 1, (b_wr_n % NWB) % (BW - 2) + 1,
                             pix((b_wr_n % NWB) / (BW - 2) + 1, (b_wr_n % NWB) % (BW - 2) + 1));
                end
                b_wr_n <= b_wr_n + 1;
            end
            if ((rd_b && pb_rd && (addr_row_r_b !== pb_rr || addr_col_r_b !== pb_rc)) ||
                (wr_b && pb_wr && (addr_row_w_b !== pb_wr_r || addr_col_w_b !== pb_wc || cl_pixel_b !== pb_wv))) begin
                b_err <= b_err + 1;
                $display("FAIL b_pair_hold got rd=%0b wr=%0b addr changed want held", rd_b, wr_b);
            end
            if (done_b) b_done_n <= b_done_n + 1;
            pb_rd <= rd_b; pb_wr <= wr_b;
            pb_rr <= addr_row_r_b; pb_rc <= addr_col_r_b;
            pb_wr_r <= addr_row_w_b; pb_wc <= addr_col_w_b; pb_wv <= cl_pixel_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
        start_b = 1'b0; win_ready_b = 1'b0; res_valid_b = 1'b0;
        step(); step();
        total++;
        if ({busy, done, rd, wr, win_valid, res_ready} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, rd, wr, win_valid, res_ready});
        end
        total++;
        if ({addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel} !== 40'd0) begin
            bad++; $display("FAIL reset_addr got %h want 0", {addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel});
        end
        total++;
        if (win_data !== 72'd0 || busy_b !== 1'b0) begin
            bad++; $display("FAIL reset_win got %h busy_b=%b want 0", win_data, busy_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_scan();
        int rb, wb, db, done_at, first_wv, k;
        logic [71:0] wd0;
        rb = a_rd_n; wb = a_wr_n; db = a_done_n; done_at = -1; first_wv = -1; wd0 = '0;
        win_ready = 1'b1; res_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 100 && done_at < 0; n++) begin
            if (win_valid && first_wv < 0) begin first_wv = n; wd0 = win_data; end
            if (done) done_at = n; else step();
        end
        total++;
        if (done_at != 33) begin bad++; $display("FAIL full_done_cycle got %0d want 33", done_at); end
        total++;
        if (first_wv != 4) begin bad++; $display("FAIL full_first_win_valid got %0d want 4", first_wv); end
        total++;
        if (wd0 !== 72'h22_21_20_12_11_10_02_01_00) begin
            bad++; $display("FAIL capture_order got %h want 222120121110020100", wd0);
        end
        total++;
        if (a_rd_n - rb != 4 || a_wr_n - wb != 4) begin
            bad++; $display("FAIL full_counts got rd=%0d wr=%0d want 4 4", a_rd_n - rb, a_wr_n - wb);
        end
        k = 0;
        for (int r = 0; r <= AH - 3; r++)
            for (int c = 0; c <= AW - 3; c++) begin
                total++;
                if (int'(a_rd_r[(rb + k) % 64]) != r || int'(a_rd_c[(rb + k) % 64]) != c) begin
                    bad++; $display("FAIL full_rd_addr got (%0d,%0d) want (%0d,%0d)", a_rd_r[(rb + k) % 64], a_rd_c[(rb + k) % 64], r, c);
                end
                total++;
                if (int'(a_wr_r[(wb + k) % 64]) != r + 1 || int'(a_wr_c[(wb + k) % 64]) != c + 1 || a_wr_v[(wb + k) % 64] !== pix(r + 1, c + 1)) begin
                    bad++; $display("FAIL full_wr got (%0d,%0d)=%h want (%0d,%0d)=%h", a_wr_r[(wb + k) % 64], a_wr_c[(wb + k) % 64],
                                    a_wr_v[(wb + k) % 64], r + 1, c + 1, pix(r + 1, c + 1));
                end
                k++;
            end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL full_after_done got busy=%b done=%b want 0 0", busy, done); end
        step(); step();
        total++;
        if (a_done_n - db != 1) begin bad++; $display("FAIL full_done_pulses got %0d want 1", a_done_n - db); end
    endtask

    task automatic test_stalls();
        int done_at;
        logic [71:0] wd;
        done_at = -1; wd = '0;
        win_ready = 1'b0; res_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            win_ready = (n >= 9);
            res_valid = (n >= 13);
            if (n == 4) wd = win_data;
            if (n >= 4 && n <= 9) begin
                total++;
                if (win_valid !== 1'b1 || win_data !== wd) begin
                    bad++; $display("FAIL stall_win_hold cyc %0d got valid=%b data=%h want 1 %h", n, win_valid, win_data, wd);
                end
            end
            if (n >= 4 && n <= 13) begin
                total++;
                if (rd !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL stall_idle_bus cyc %0d got rd=%b wr=%b want 0 0", n, rd, wr); end
            end
            if (n == 14 || n == 15) begin
                total++;
                if (wr !== 1'b1 || addr_row_w !== 8'd1 || addr_col_w !== 8'd1 || cl_pixel !== 8'h11) begin
                    bad++; $display("FAIL stall_write cyc %0d got wr=%b (%0d,%0d)=%h want 1 (1,1)=11", n, wr, addr_row_w, addr_col_w, cl_pixel);
                end
            end
            if (n == 16) begin
                total++;
                if (rd !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL stall_adv got rd=%b wr=%b want 0 0", rd, wr); end
            end
            if (n == 17) begin
                total++;
                if (rd !== 1'b1 || addr_row_r !== 8'd0 || addr_col_r !== 8'd1) begin
                    bad++; $display("FAIL stall_next_read got rd=%b (%0d,%0d) want 1 (0,1)", rd, addr_row_r, addr_col_r);
                end
            end
            if (n < 17) step();
        end
        win_ready = 1'b1; res_valid = 1'b1;
        for (int n = 17; n <= 100 && done_at < 0; n++) begin
            if (done) done_at = n; else step();
        end
        total++;
        if (done_at != 41) begin bad++; $display("FAIL stall_done_cycle got %0d want 41", done_at); end
        step();
    endtask

    task automatic test_reset_mid();
        int wb, done_at;
        logic found;
        found = 1'b0; done_at = -1;
        win_ready = 1'b1; res_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            if (wr) found = 1'b1; else step();
        end
        total++;
        if (!found) begin bad++; $display("FAIL rstmid_find_write got none want wr within 20 cycles"); end
        rst = 1'b1;
        step();
        total++;
        if ({busy, done, rd, wr, win_valid, res_ready} !== 6'b0 ||
            {addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel} !== 40'd0 || win_data !== 72'd0) begin
            bad++; $display("FAIL rstmid_outputs got ctrl=%b addr=%h win=%h want 0", {busy, done, rd, wr, win_valid, res_ready},
                            {addr_row_r, addr_col_r, addr_row_w, addr_col_w, cl_pixel}, win_data);
        end
        rst = 1'b0;
        wb = a_wr_n;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (rd !== 1'b1 || addr_row_r !== 8'd0 || addr_col_r !== 8'd0) begin
            bad++; $display("FAIL rstmid_restart got rd=%b (%0d,%0d) want 1 (0,0)", rd, addr_row_r, addr_col_r);
        end
        for (int n = 1; n <= 100 && done_at < 0; n++) begin
            if (done) done_at = n; else step();
        end
        total++;
        if (done_at != 33 || a_wr_n - wb != 4 || a_wr_v[wb % 64] !== 8'h11) begin
            bad++; $display("FAIL rstmid_rescan got done=%0d writes=%0d first=%h want 33 4 11", done_at, a_wr_n - wb, a_wr_v[wb % 64]);
        end
        step();
    endtask

    task automatic test_ignored_start();
        int wb, db, done_at;
        logic late_busy;
        wb = a_wr_n; db = a_done_n; done_at = -1; late_busy = 1'b0;
        win_ready = 1'b1; res_valid = 1'b1; start = 1'b1;
        step();
        for (int n = 1; n <= 100 && done_at < 0; n++) begin
            start = (n == 3 || n == 10 || n == 20 || n == 31);
            if (done) done_at = n; else step();
        end
        // Held high through the DONE cycle only; IDLE must not see it
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (busy) late_busy = 1'b1;
            step();
        end
        total++;
        if (done_at != 33) begin bad++; $display("FAIL ign_done_cycle got %0d want 33", done_at); end
        total++;
        if (a_done_n - db != 1 || late_busy) begin
            bad++; $display("FAIL ign_single_done got pulses=%0d restart=%b want 1 0", a_done_n - db, late_busy);
        end
        total++;
        if (a_wr_n - wb != 4 || a_wr_v[(wb + 3) % 64] !== 8'h22 || a_wr_r[(wb + 3) % 64] !== 8'd2 || a_wr_c[(wb + 3) % 64] !== 8'd2) begin
            bad++; $display("FAIL ign_writes got n=%0d last=(%0d,%0d)=%h want 4 (2,2)=22", a_wr_n - wb,
                            a_wr_r[(wb + 3) % 64], a_wr_c[(wb + 3) % 64], a_wr_v[(wb + 3) % 64]);
        end
        total++;
        if (a_conf != 0 || a_hold != 0) begin
            bad++; $display("FAIL a_mutex_hold got overlap=%0d hold_err=%0d want 0 0", a_conf, a_hold);
        end
    endtask

    task automatic test_random_backpressure();
        int rn, wn, dn, c0, e0;
        logic got;
        rn = b_rd_n; wn = b_wr_n; dn = b_done_n; c0 = b_conf; e0 = b_err;
        for (int s = 0; s < 3; s++) begin
            got = 1'b0;
            start_b = 1'b1;
            step();
            start_b = 1'b0;
            for (int n = 0; n < 4000 && !got; n++) begin
                win_ready_b = 1'($urandom_range(0, 1));
                res_valid_b = 1'($urandom_range(0, 1));
                start_b = busy_b && ($urandom_range(0, 7) == 0);
                step();
                if (done_b) got = 1'b1;
            end
            start_b = 1'b0;
            total++;
            if (!got) begin bad++; $display("FAIL rand_timeout scan %0d got no done want done", s); end
            step();
        end
        total++;
        if (b_wr_n - wn != 3 * NWB || b_rd_n - rn != 3 * NWB) begin
            bad++; $display("FAIL rand_counts got rd=%0d wr=%0d want %0d", b_rd_n - rn, b_wr_n - wn, 3 * NWB);
        end
        total++;
        if (b_conf != c0) begin bad++; $display("FAIL rand_mutex got overlaps=%0d want 0", b_conf - c0); end
        total++;
        if (b_err != e0) begin bad++; $display("FAIL rand_seq_hold got errors=%0d want 0", b_err - e0); end
        total++;
        if (b_done_n - dn != 3) begin bad++; $display("FAIL rand_done_pulses got %0d want 3", b_done_n - dn); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_stalls();
        test_reset_mid();
        test_ignored_start();
        test_random_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
